// File: rtl/nv_nvdla_pdp_wdma_datpack_pkg.sv
// Shared PDP write-DMA definitions: bus widths and the packer state encoding.
package nv_nvdla_pdp_wdma_datpack_pkg;

  localparam int ATOM_W         = 256;
  localparam int BEAT_W         = 64;
  localparam int BEATS_PER_ATOM = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wdma_state_e;

endpackage

// File: rtl/nv_nvdla_pdp_wdma_addr_gen.sv
// Pixel/line/surface counters and the atom address for the beat currently offered.
module nv_nvdla_pdp_wdma_addr_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        beat_acc,
  input  logic [63:0] base_addr,
  input  logic [31:0] line_stride,
  input  logic [31:0] surface_stride,
  input  logic [12:0] width,
  input  logic [12:0] height,
  input  logic [12:0] channel,
  output logic [1:0]  slot,
  output logic        line_end,
  output logic        last_beat,
  output logic [63:0] atom_addr
);

  logic [12:0] width_q, width_d, height_q, height_d;
  logic [9:0]  slast_q, slast_d;
  logic [31:0] ls_q, ls_d, ss_q, ss_d;
  logic [12:0] x_q, x_d, y_q, y_d;
  logic [9:0]  s_q, s_d;
  logic [63:0] line_q, line_d, surf_q, surf_d;
  logic        surf_end_s;
  logic        unused_ch_lo;

  assign unused_ch_lo = &{1'b0, channel[2:0]};

  // Line and surface start addresses are kept incrementally, so no multipliers are needed.
  assign slot       = x_q[1:0];
  assign line_end   = (x_q == width_q);
  assign surf_end_s = (y_q == height_q);
  assign last_beat  = line_end && surf_end_s && (s_q == slast_q);
  assign atom_addr  = line_q + {48'd0, x_q[12:2], 5'd0};

  // Counter and config next-state.
  always_comb begin
    width_d  = width_q;
    height_d = height_q;
    slast_d  = slast_q;
    ls_d     = ls_q;
    ss_d     = ss_q;
    x_d      = x_q;
    y_d      = y_q;
    s_d      = s_q;
    line_d   = line_q;
    surf_d   = surf_q;
    if (load) begin
      width_d  = width;
      height_d = height;
      slast_d  = channel[12:3];
      ls_d     = line_stride;
      ss_d     = surface_stride;
      x_d      = 13'd0;
      y_d      = 13'd0;
      s_d      = 10'd0;
      line_d   = base_addr;
      surf_d   = base_addr;
    end else if (beat_acc) begin
      if (!line_end) begin
        x_d = x_q + 13'd1;
      end else begin
        x_d = 13'd0;
        if (!surf_end_s) begin
          y_d    = y_q + 13'd1;
          line_d = line_q + {32'd0, ls_q};
        end else begin
          y_d    = 13'd0;
          s_d    = (s_q == slast_q) ? 10'd0 : s_q + 10'd1;
          surf_d = surf_q + {32'd0, ss_q};
          line_d = surf_q + {32'd0, ss_q};
        end
      end
    end else begin
      x_d = x_q;
    end
  end

  // Counter and config registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q  <= 13'd0;
      height_q <= 13'd0;
      slast_q  <= 10'd0;
      ls_q     <= 32'd0;
      ss_q     <= 32'd0;
      x_q      <= 13'd0;
      y_q      <= 13'd0;
      s_q      <= 10'd0;
      line_q   <= 64'd0;
      surf_q   <= 64'd0;
    end else begin
      width_q  <= width_d;
      height_q <= height_d;
      slast_q  <= slast_d;
      ls_q     <= ls_d;
      ss_q     <= ss_d;
      x_q      <= x_d;
      y_q      <= y_d;
      s_q      <= s_d;
      line_q   <= line_d;
      surf_q   <= surf_d;
    end
  end

endmodule

// File: rtl/nv_nvdla_pdp_wdma_datpack.sv
// PDP write-DMA packer: gathers 64-bit pixel beats into 256-bit atoms with masks and addresses.
module nv_nvdla_pdp_wdma_datpack
  import nv_nvdla_pdp_wdma_datpack_pkg::*;
(
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                op_load,
  input  logic [63:0]         reg2dp_dst_base_addr,
  input  logic [31:0]         reg2dp_dst_line_stride,
  input  logic [31:0]         reg2dp_dst_surface_stride,
  input  logic [12:0]         reg2dp_cube_out_width,
  input  logic [12:0]         reg2dp_cube_out_height,
  input  logic [12:0]         reg2dp_cube_out_channel,
  input  logic                pdp_dp2wdma_valid,
  output logic                pdp_dp2wdma_ready,
  input  logic [BEAT_W-1:0]   pdp_dp2wdma_pd,
  output logic                dma_wr_req_valid,
  input  logic                dma_wr_req_ready,
  output logic [63:0]         dma_wr_req_addr,
  output logic [ATOM_W-1:0]   dma_wr_req_data,
  output logic [BEATS_PER_ATOM-1:0] dma_wr_req_mask,
  output logic                wdma_done
);

  wdma_state_e state_q, state_d;
  logic [ATOM_W-1:0]         acc_data_q, acc_data_d, fill_data_s;
  logic [BEATS_PER_ATOM-1:0] acc_mask_q, acc_mask_d, fill_mask_s;
  logic [63:0]               acc_addr_q, acc_addr_d;
  logic                      acc_pend_q, acc_pend_d;
  logic                      req_valid_q, req_valid_d;
  logic [63:0]               req_addr_q, req_addr_d;
  logic [ATOM_W-1:0]         req_data_q, req_data_d;
  logic [BEATS_PER_ATOM-1:0] req_mask_q, req_mask_d;
  logic [1:0]  slot_s;
  logic        line_end_s, last_beat_s, load_s, in_ready_s, beat_acc_s;
  logic        out_free_s, close_s, final_acc_s;
  logic [63:0] atom_addr_s;

  assign load_s      = op_load && (state_q == ST_IDLE);
  assign in_ready_s  = (state_q == ST_RUN) && !acc_pend_q;
  assign beat_acc_s  = pdp_dp2wdma_valid && in_ready_s;
  assign out_free_s  = !req_valid_q || dma_wr_req_ready;
  assign final_acc_s = (state_q == ST_DRAIN) && req_valid_q && dma_wr_req_ready && !acc_pend_q;

  nv_nvdla_pdp_wdma_addr_gen u_addr_gen (
    .clk            (nvdla_core_clk),
    .rst            (nvdla_core_rst),
    .load           (load_s),
    .beat_acc       (beat_acc_s),
    .base_addr      (reg2dp_dst_base_addr),
    .line_stride    (reg2dp_dst_line_stride),
    .surface_stride (reg2dp_dst_surface_stride),
    .width          (reg2dp_cube_out_width),
    .height         (reg2dp_cube_out_height),
    .channel        (reg2dp_cube_out_channel),
    .slot           (slot_s),
    .line_end       (line_end_s),
    .last_beat      (last_beat_s),
    .atom_addr      (atom_addr_s)
  );

  // Accumulator contents with the offered beat merged in; slots fill contiguously from 0.
  always_comb begin
    fill_data_s = acc_data_q;
    fill_mask_s = acc_mask_q;
    fill_data_s[{slot_s, 6'd0} +: BEAT_W] = pdp_dp2wdma_pd;
    fill_mask_s[slot_s] = 1'b1;
    close_s = beat_acc_s && ((slot_s == 2'd3) || line_end_s);
  end

  // Accumulator and output register: a closed atom moves on at once or parks as pending.
  always_comb begin
    acc_data_d  = acc_data_q;
    acc_mask_d  = acc_mask_q;
    acc_addr_d  = acc_addr_q;
    acc_pend_d  = acc_pend_q;
    req_valid_d = req_valid_q && !dma_wr_req_ready;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_mask_d  = req_mask_q;
    if (load_s) begin
      acc_data_d = '0;
      acc_mask_d = '0;
      acc_pend_d = 1'b0;
    end else if (acc_pend_q) begin
      if (out_free_s) begin
        req_valid_d = 1'b1;
        req_addr_d  = acc_addr_q;
        req_data_d  = acc_data_q;
        req_mask_d  = acc_mask_q;
        acc_data_d  = '0;
        acc_mask_d  = '0;
        acc_pend_d  = 1'b0;
      end else begin
        acc_pend_d = 1'b1;
      end
    end else if (close_s) begin
      if (out_free_s) begin
        req_valid_d = 1'b1;
        req_addr_d  = atom_addr_s;
        req_data_d  = fill_data_s;
        req_mask_d  = fill_mask_s;
        acc_data_d  = '0;
        acc_mask_d  = '0;
      end else begin
        acc_data_d = fill_data_s;
        acc_mask_d = fill_mask_s;
        acc_addr_d = atom_addr_s;
        acc_pend_d = 1'b1;
      end
    end else if (beat_acc_s) begin
      acc_data_d = fill_data_s;
      acc_mask_d = fill_mask_s;
    end else begin
      acc_pend_d = acc_pend_q;
    end
  end

  // Layer state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (op_load) state_d = ST_RUN; else state_d = ST_IDLE;
      ST_RUN:   if (beat_acc_s && last_beat_s) state_d = ST_DRAIN; else state_d = ST_RUN;
      ST_DRAIN: if (final_acc_s) state_d = ST_IDLE; else state_d = ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q     <= ST_IDLE;
      acc_data_q  <= '0;
      acc_mask_q  <= '0;
      acc_addr_q  <= 64'd0;
      acc_pend_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 64'd0;
      req_data_q  <= '0;
      req_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_data_q  <= acc_data_d;
      acc_mask_q  <= acc_mask_d;
      acc_addr_q  <= acc_addr_d;
      acc_pend_q  <= acc_pend_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_mask_q  <= req_mask_d;
    end
  end

  assign pdp_dp2wdma_ready = in_ready_s;
  assign dma_wr_req_valid  = req_valid_q;
  assign dma_wr_req_addr   = req_addr_q;
  assign dma_wr_req_data   = req_data_q;
  assign dma_wr_req_mask   = req_mask_q;
  assign wdma_done         = final_acc_s;

endmodule
